// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM with per-lane write enables, 1- or 2-cycle registered read,
// selectable read-during-write policy and a zero-fill clear sequencer.
module sdp_ram_be #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 4,
  parameter int unsigned LW       = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  output logic                 busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [DW/LW-1:0]     wr_be,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid
);

  localparam int unsigned DP = 1 << AW;
  localparam int unsigned NL = DW / LW;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [DW-1:0] mem [DP];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          busy_d;

  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;
  logic          rd_accept_c;
  logic [DW-1:0] rd_word_c;
  logic [DW-1:0] wr_old_c;
  logic [DW-1:0] wr_merged_c;

  // Lane merge of incoming write data over the current word
  assign wr_old_c = mem[wr_addr];
  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign wr_merged_c[g*LW +: LW] = wr_be[g] ? wr_data[g*LW +: LW] : wr_old_c[g*LW +: LW];
  end

  // Next-state, clear sequencing and port acceptance
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    busy_d      = busy;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr;
    mem_wdata_c = wr_merged_c;
    rd_accept_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ptr_q;
        mem_wdata_c = '0;
        clr_ptr_d   = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DP - 1)) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end else begin
          mem_we_c    = wr_en;
          rd_accept_c = rd_en;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  // New-data mode forwards the merged word on a same-address collision
  assign rd_word_c = (RDW_MODE == 1 && mem_we_c && mem_waddr_c == rd_addr) ? wr_merged_c
                                                                           : mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy      <= busy_d;
    end
  end

  // Array has no reset; the clear sequencer zero-fills it
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] s1_data_q;
    logic          s1_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
        rd_data    <= '0;
        rd_valid   <= 1'b0;
      end else begin
        s1_valid_q <= rd_accept_c;
        if (rd_accept_c) s1_data_q <= rd_word_c;
        rd_valid <= s1_valid_q;
        if (s1_valid_q) rd_data <= s1_data_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_accept_c;
        if (rd_accept_c) rd_data <= rd_word_c;
      end
    end
  end

endmodule
